// File: rtl/ram_arb_pkg.sv
// Shared definitions for the data-RAM arbiter and the core top level.
//   - arb_state_e : arbiter FSM state encoding
//   - DefAddrW    : default byte-address width of the data RAM
//   - DefDataW    : default data width of the data RAM
package ram_arb_pkg;

  localparam int unsigned DefAddrW = 12;
  localparam int unsigned DefDataW = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker.
//   req    : request vector, bit 0 = port 0, bit 1 = port 1
//   last   : port that performed the most recent access
//   winner : selected port; meaningful only when req is non-zero
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    unique case (req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;  // tie goes to the port that did not go last
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the CPU data port (m0) and the
// loader/DMA/debug port (m1). Round-robin arbitration with an optional lock that
// lets an owner keep the RAM for at most MAX_BURST consecutive cycles while the
// other port waits. An uncontended owner keeps the RAM indefinitely.
//   clk, rst            : clock, synchronous active-high reset
//   mX_req/we/addr/wdata: access request from port X, held until acked
//   mX_lock             : ask to keep ownership for the next access
//   mX_gnt              : port X owns the RAM (registered)
//   mX_ack              : access performed this cycle
//   mX_rdata            : read data, valid when ack & !we
//   ram_we/addr/d_in    : RAM control, all zero when no port is acking
//   ram_d_out           : combinational RAM read data
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_d_in,
  input  logic [DATA_W-1:0] ram_d_out
);

  localparam int unsigned   CntW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_BURST - 1);

  arb_state_e      state_q, state_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic winner;
  logic own_sel, own_req, own_lock, oth_req;

  rr_arb2 u_rr_arb2 (
    .req    ({m1_req, m0_req}),
    .last   (last_q),
    .winner (winner)
  );

  // Grant, acknowledge and RAM port steering
  always_comb begin
    m0_gnt   = (state_q == StOwn0);
    m1_gnt   = (state_q == StOwn1);
    m0_ack   = m0_gnt & m0_req & ~rst;
    m1_ack   = m1_gnt & m1_req & ~rst;
    m0_rdata = m0_ack ? ram_d_out : '0;
    m1_rdata = m1_ack ? ram_d_out : '0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_d_in = '0;
    if (m0_ack) begin
      ram_we   = m0_we;
      ram_addr = m0_addr;
      ram_d_in = m0_wdata;
    end else if (m1_ack) begin
      ram_we   = m1_we;
      ram_addr = m1_addr;
      ram_d_in = m1_wdata;
    end
  end

  // Current owner's view of the requests, so both OWN states share one rule set
  always_comb begin
    own_sel  = (state_q == StOwn1);
    own_req  = own_sel ? m1_req  : m0_req;
    own_lock = own_sel ? m1_lock : m0_lock;
    oth_req  = own_sel ? m0_req  : m1_req;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (m0_ack) last_d = 1'b0;
    if (m1_ack) last_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (m0_req || m1_req) state_d = winner ? StOwn1 : StOwn0;
      end
      StOwn0, StOwn1: begin
        if (own_req && own_lock && oth_req && (cnt_q < CntLast)) begin
          cnt_d = cnt_q + 1'b1;
        end else if (oth_req) begin
          state_d = own_sel ? StOwn0 : StOwn1;
          cnt_d   = '0;
        end else if (own_req) begin
          cnt_d = '0;
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;  // port 0 wins the first tie
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
